awb_gain: RTL and testbench
===========================

# awb_gain

Gray-world auto-white-balance gain stage that consumes the per-channel means produced at the end of a statistics pass. It computes the red and blue gains relative to green with a sequential divider. It then applies those gains to the pixel stream of the next pass. It sits downstream of the mean-statistics block and uses the same valid/color/value/last pixel stream format.

## Interface
- GAIN_FRAC, 6, fractional bits of gains (Q2.6); unity gain = 64
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- finish_i  in  1  one-cycle pulse; means are valid this cycle
- r_mean_i, g_mean_i, b_mean_i  in  8 each  channel means
- valid_i  in  1  pixel valid
- color_i  in  2  0=R, 1=G, 2=B, 3=reserved
- value_i  in  8  pixel value
- last_i  in  1  last pixel of frame
- valid_o, color_o, value_o, last_o  out  1/2/8/1  corrected pixel stream
- r_gain_o, b_gain_o  out  8 each  active gains (Q2.6)
- ready_o  out  1  gains computed at least once since reset (sticky)
- busy_o  out  1  divider running

## Operation
- FSM states: IDLE, DIV_R, DIV_B, DONE.
- IDLE or DONE with finish_i=1:
  - Latch the three means.
  - Go to DIV_R.
- finish_i while in DIV_R or DIV_B is ignored.
- Divider: restoring, 1 quotient bit per cycle, 14 cycles per channel.
  - Dividend = {g_mean, 6'b0} (14 bits); divisor = r_mean (DIV_R) or b_mean (DIV_B).
  - Quotient > 255 saturates to 255.
  - Divisor 0 gives 255. The full 14 cycles still elapse, so latency is fixed.
- Gain update:
  - The DIV_R result is held in a pending register.
  - On exit of DIV_B, r_gain_o and b_gain_o update together (atomic), then FSM enters DONE and ready_o sets.
  - Old gains stay active throughout a recompute.
- DONE behaves like IDLE for new finish_i.
- Pixel path, applied every valid_i beat regardless of FSM state:
  - R: out = sat8((value × r_gain + RND) >> 6)
  - B: out = sat8((value × b_gain + RND) >> 6)
  - G and color 3: passed through unchanged.
  - Before ready_o is set, R and B are also passed through unchanged (unity).
- Widths: product 16 bits, plus RND = 17 bits; after >>6 the result is 11 bits; any value > 255 saturates to 255.
- color_o and last_o travel aligned with value_o. No backpressure; no input is ever dropped.

## Timing
- Reset values:
  - valid_o, last_o, ready_o, busy_o = 0; color_o, value_o = 0.
  - r_gain_o = b_gain_o = 64; FSM = IDLE.
- Pixel latency: 2 cycles. Stage 1 registers the input; stage 2 registers the multiplied/saturated result. Full throughput, one pixel per clock.
- Gain latency:
  - finish_i sampled at edge k.
  - busy_o = 1 from edge k+1 through edge k+28.
  - Gains and ready_o are visible after edge k+29.
- A pixel sampled into stage 1 uses the gains present in that same cycle. A gain change mid-frame takes effect on the next stage-1 pixel.
- finish_i on the same edge as the DIV_B→DONE transition: that edge completes the update; the pulse is ignored, because the FSM was busy when it was sampled.
- rst_n asserted mid-division: the divider aborts, all registers return to reset values, and the pending gain is discarded.

## Configuration
- AWB_ROUND_EN defined: RND = 32 (round-half-up).
- AWB_ROUND_EN undefined: RND = 0 (truncate).
- Gain computation is unaffected by the macro; only the pixel multiply path changes.

## Test plan
- Reset, then R pixel 100 with no finish_i → value_o = 100 two cycles later; ready_o = 0, gains = 64.
- Means R=64, G=128, B=32, finish_i pulse → busy_o high for 28 cycles; then r_gain_o = 128, b_gain_o = 255 (saturated), ready_o = 1.
- With those gains:
  - R 100 → 200.
  - B 100 → 255 (saturated).
  - G 77 → 77.
  - Color 3 value 9 → 9.
  - last_i is carried through with 2-cycle alignment.
- Means R=0, G=50, B=100 → r_gain_o = 255, b_gain_o = 32. B 201 → 101 with AWB_ROUND_EN, 100 without.
- Second finish_i pulse at cycle 10 of a running division: it is ignored, and the gains match the first means. A new pulse in DONE with equal means (all 100) → both gains = 64; pixel 200 → 200.
- rst_n pulsed at cycle 20 of a division → busy_o = 0, gains = 64, ready_o = 0, and no gain update occurs afterwards.

Source files
------------

// File: rtl/awb_gain.sv
// awb_gain: gray-world auto-white-balance gain stage.
//
// Takes the per-channel means produced at the end of a statistics pass and
// computes red and blue gains relative to green (Q2.6, unity = 64). A
// restoring divider produces one quotient bit per cycle, 14 cycles per
// channel. The gains are then applied to the pixel stream of the following
// pass.
//
// Optional feature: define AWB_ROUND_EN to round the pixel multiply
// half-up (RND = 32). When it is undefined the multiply truncates (RND = 0).
// Gain computation is the same either way.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   finish_i             one-cycle pulse, means valid this cycle
//   r/g/b_mean_i [7:0]   channel means
//   valid_i, color_i[1:0], value_i[7:0], last_i   input pixel stream
//   valid_o, color_o[1:0], value_o[7:0], last_o   corrected stream (2-cycle latency)
//   r_gain_o, b_gain_o   active gains (Q2.6)
//   ready_o              sticky, gains computed at least once since reset
//   busy_o               divider running
//   dbg_state[1:0]       FSM state (0 IDLE, 1 DIV_R, 2 DIV_B, 3 DONE)
//
// Handshake: the pixel stream has no backpressure. A beat is taken on every
// edge where valid_i is high and appears on the outputs with valid_o high
// exactly two edges later. finish_i is a pulse that is honoured only in IDLE
// or DONE; a pulse seen in DIV_R or DIV_B (including the final DIV_B edge)
// is dropped.

module awb_gain #(
  parameter int GAIN_FRAC = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       finish_i,
  input  logic [7:0] r_mean_i,
  input  logic [7:0] g_mean_i,
  input  logic [7:0] b_mean_i,
  input  logic       valid_i,
  input  logic [1:0] color_i,
  input  logic [7:0] value_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic [1:0] color_o,
  output logic [7:0] value_o,
  output logic       last_o,
  output logic [7:0] r_gain_o,
  output logic [7:0] b_gain_o,
  output logic       ready_o,
  output logic       busy_o,
  output logic [1:0] dbg_state
);

  localparam int DW = 8 + GAIN_FRAC;           // dividend width
  localparam int CW = $clog2(DW + 1);          // step counter width
  localparam int SW = 17 - GAIN_FRAC;          // scaled product width
  localparam logic [7:0] UNITY = 8'(1 << GAIN_FRAC);
`ifdef AWB_ROUND_EN
  localparam logic [16:0] RND = 17'(1 << (GAIN_FRAC - 1));
`else
  localparam logic [16:0] RND = 17'd0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV_R = 2'd1,
    DIV_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [7:0]      r_mean_q, g_mean_q, b_mean_q;
  logic [DW-1:0]   dvd;
  logic [DW-1:0]   quo;
  logic [7:0]      rem;
  logic [CW-1:0]   cnt;
  logic [7:0]      r_pend, b_pend;

  assign dbg_state = state;

  // One restoring-division step. The remainder is always below the divisor,
  // so the 8-bit wrap-around subtraction is exact whenever it is taken.
  // A zero divisor takes every bit, giving an all-ones quotient that the
  // saturation below turns into 255.
  logic [7:0]    divisor;
  logic [8:0]    rem_sh;
  logic          take;
  logic [7:0]    rem_nx;
  logic [DW-1:0] quo_nx;
  logic [7:0]    quo_sat;

  always_comb begin
    divisor = (state == DIV_B) ? b_mean_q : r_mean_q;
    rem_sh  = {rem, dvd[DW-1]};
    take    = (rem_sh >= {1'b0, divisor});
    rem_nx  = take ? (rem_sh[7:0] - divisor) : rem_sh[7:0];
    quo_nx  = {quo[DW-2:0], take};
    quo_sat = (quo_nx > DW'(255)) ? 8'hFF : quo_nx[7:0];
  end

  // Control FSM. DIV_R spends 14 edges stepping, DIV_B spends 14 edges
  // stepping plus one exit edge that publishes both gains at once, which
  // places the gain update 29 edges after the accepted finish_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      r_mean_q <= '0;
      g_mean_q <= '0;
      b_mean_q <= '0;
      dvd      <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      r_pend   <= UNITY;
      b_pend   <= UNITY;
      r_gain_o <= UNITY;
      b_gain_o <= UNITY;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (finish_i) begin
            r_mean_q <= r_mean_i;
            g_mean_q <= g_mean_i;
            b_mean_q <= b_mean_i;
            dvd      <= {g_mean_i, {GAIN_FRAC{1'b0}}};
            quo      <= '0;
            rem      <= '0;
            cnt      <= '0;
            state    <= DIV_R;
          end
        end
        DIV_R: begin
          busy_o <= 1'b1;
          if (cnt == CW'(DW - 1)) begin
            r_pend <= quo_sat;
            dvd    <= {g_mean_q, {GAIN_FRAC{1'b0}}};
            quo    <= '0;
            rem    <= '0;
            cnt    <= '0;
            state  <= DIV_B;
          end else begin
            dvd <= {dvd[DW-2:0], 1'b0};
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + 1'b1;
          end
        end
        DIV_B: begin
          if (cnt == CW'(DW)) begin
            r_gain_o <= r_pend;
            b_gain_o <= b_pend;
            ready_o  <= 1'b1;
            busy_o   <= 1'b0;
            state    <= DONE;
          end else begin
            busy_o <= 1'b1;
            dvd    <= {dvd[DW-2:0], 1'b0};
            rem    <= rem_nx;
            quo    <= quo_nx;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(DW - 1)) b_pend <= quo_sat;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel stage 1: capture the beat together with the gain that is active
  // on this edge. Green, reserved color and everything before the first
  // gain computation use unity, which passes the value through unchanged.
  logic       s1_valid, s1_last;
  logic [1:0] s1_color;
  logic [7:0] s1_value, s1_gain;
  logic [7:0] gain_sel;

  always_comb begin
    gain_sel = UNITY;
    if (ready_o) begin
      if (color_i == 2'd0)      gain_sel = r_gain_o;
      else if (color_i == 2'd2) gain_sel = b_gain_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_color <= '0;
      s1_value <= '0;
      s1_gain  <= UNITY;
    end else begin
      s1_valid <= valid_i;
      s1_last  <= last_i;
      s1_color <= color_i;
      s1_value <= value_i;
      s1_gain  <= gain_sel;
    end
  end

  // Pixel stage 2: multiply, round, scale back and saturate to 8 bits.
  logic [15:0]   prod;
  logic [16:0]   sum;
  logic [SW-1:0] scaled;

  always_comb begin
    prod   = 16'(s1_value) * 16'(s1_gain);
    sum    = {1'b0, prod} + RND;
    scaled = SW'(sum >> GAIN_FRAC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      color_o <= '0;
      value_o <= '0;
    end else begin
      valid_o <= s1_valid;
      last_o  <= s1_last;
      color_o <= s1_color;
      value_o <= (scaled > SW'(255)) ? 8'hFF : scaled[7:0];
    end
  end

endmodule

// File: tb/tb_awb_gain.sv
// Bench for awb_gain: directed scenarios plus randomized frames, checked
// against a behavioural model of the gray-world gain rules.

module tb_awb_gain;

`ifdef AWB_ROUND_EN
  localparam int RND = 32;
`else
  localparam int RND = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       finish_i;
  logic [7:0] r_mean_i, g_mean_i, b_mean_i;
  logic       valid_i, last_i;
  logic [1:0] color_i;
  logic [7:0] value_i;
  logic       valid_o, last_o;
  logic [1:0] color_o;
  logic [7:0] value_o;
  logic [7:0] r_gain_o, b_gain_o;
  logic       ready_o, busy_o;
  logic [1:0] dbg_state;

  awb_gain dut (
    .clk(clk), .rst_n(rst_n), .finish_i(finish_i),
    .r_mean_i(r_mean_i), .g_mean_i(g_mean_i), .b_mean_i(b_mean_i),
    .valid_i(valid_i), .color_i(color_i), .value_i(value_i), .last_i(last_i),
    .valid_o(valid_o), .color_o(color_o), .value_o(value_o), .last_o(last_o),
    .r_gain_o(r_gain_o), .b_gain_o(b_gain_o), .ready_o(ready_o),
    .busy_o(busy_o), .dbg_state(dbg_state)
  );

  // scoreboard
  logic [10:0] exp_q[$];   // {last, color, value}
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // behavioural model: active gains, plus a pending result that becomes
  // active 29 edges after the accepted finish edge
  int m_r = 64, m_b = 64;
  bit m_ready = 0;
  bit p_on = 0;
  int p_k = 0, p_r = 0, p_b = 0;

  function automatic int gain_ref(input int g, input int d);
    int q;
    if (d == 0) return 255;
    q = (g * 64) / d;
    return (q > 255) ? 255 : q;
  endfunction

  function automatic int pix_ref(input int col, input int v);
    int g, o;
    if (!m_ready || col == 1 || col == 3) return v;
    g = (col == 0) ? m_r : m_b;
    o = (v * g + RND) / 64;
    return (o > 255) ? 255 : o;
  endfunction

  task automatic model_tick(input int c);
    if (p_on && c >= p_k + 29) begin
      m_r = p_r;
      m_b = p_b;
      m_ready = 1;
      p_on = 0;
    end
  endtask

  // driver: one call per clock; checks status after the last edge, then
  // drives inputs for the next edge
  task automatic step(input bit v, input int col, input int val, input bit lst,
                      input bit fin, input int rm, input int gm, input int bm);
    int c;
    @(negedge clk);
    c = cyc;
    model_tick(c);
    check("r_gain", r_gain_o, m_r);
    check("b_gain", b_gain_o, m_b);
    check("ready", ready_o, m_ready);
    check("busy", busy_o, (p_on && c >= p_k + 1 && c <= p_k + 28) ? 1 : 0);
    valid_i  = v;
    color_i  = 2'(col);
    value_i  = 8'(val);
    last_i   = lst;
    finish_i = fin;
    r_mean_i = 8'(rm);
    g_mean_i = 8'(gm);
    b_mean_i = 8'(bm);
    if (v) exp_q.push_back({lst, 2'(col), 8'(pix_ref(col, val))});
    if (fin && !p_on) begin
      p_on = 1;
      p_k  = c + 1;
      p_r  = gain_ref(gm, rm);
      p_b  = gain_ref(gm, bm);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pix(input int col, input int val, input bit lst);
    step(1, col, val, lst, 0, 0, 0, 0);
  endtask

  task automatic fin(input int rm, input int gm, input int bm);
    step(0, 0, 0, 0, 1, rm, gm, bm);
  endtask

  task automatic rand_pix(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255),
           ($urandom_range(0, 7) == 0), 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid_i = 1'b0;
    finish_i = 1'b0;
    m_r = 64; m_b = 64; m_ready = 0; p_on = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", 1, 0);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        check("pixel", {last_o, color_o, value_o}, e);
      end
    end
  end

  initial begin
    int rm, gm, bm;
    rst_n = 1'b0;
    finish_i = 0; valid_i = 0; color_i = 0; value_i = 0; last_i = 0;
    r_mean_i = 0; g_mean_i = 0; b_mean_i = 0;
    repeat (3) @(negedge clk);
    check("reset_valid", valid_o, 0);
    check("reset_value", value_o, 0);
    check("reset_color", color_o, 0);
    check("reset_last", last_o, 0);
    check("reset_state", dbg_state, 0);
    rst_n = 1'b1;

    // pass-through before any gains exist
    pix(0, 100, 0);
    idle(3);

    // first gain computation, old (unity) gains active while dividing
    fin(64, 128, 32);
    rand_pix(32);
    pix(0, 100, 0);
    pix(2, 100, 0);
    pix(1, 77, 0);
    pix(3, 9, 1);
    idle(3);

    // zero divisor and rounding case
    fin(0, 50, 100);
    rand_pix(31);
    pix(2, 201, 0);
    pix(0, 10, 1);
    idle(3);

    // second pulse mid-division is dropped
    fin(64, 128, 32);
    idle(9);
    fin(100, 100, 100);
    rand_pix(25);
    // new pulse in DONE with equal means
    fin(100, 100, 100);
    idle(30);
    pix(0, 200, 0);
    pix(2, 200, 1);
    idle(3);

    // pulse on the exit edge of DIV_B is dropped
    fin(0, 50, 100);
    while (cyc < p_k + 27) idle(1);
    fin(100, 100, 100);
    idle(33);
    pix(2, 201, 0);
    idle(3);

    // reset in the middle of a division discards the pending result
    fin(64, 128, 32);
    idle(19);
    do_reset();
    idle(40);
    pix(0, 100, 0);
    idle(3);

    // randomized frames, with occasional stray finish pulses
    for (int f = 0; f < 6; f++) begin
      rm = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
      gm = $urandom_range(0, 255);
      bm = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
      fin(rm, gm, bm);
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 19) == 0)
          step($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255), 0,
               1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        else
          rand_pix(1);
      end
    end

    idle(4);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
